// File: rtl/toy_pack.sv
// Shared icache/MSHR configuration and types for the refill path.
package toy_pack;

  localparam int MSHR_ENTRY_NUM         = 8;
  localparam int MSHR_ENTRY_INDEX_WIDTH = 3;
  localparam int ICACHE_INDEX_WIDTH     = 7;
  localparam int ICACHE_TAG_WIDTH       = 20;
  localparam int REFILL_BEAT_WIDTH      = 128;
  localparam int REFILL_BEAT_NUM        = 4;
  localparam int REFILL_BEAT_CNT_WIDTH  = $clog2(REFILL_BEAT_NUM);
  localparam int REQ_ADDR_WIDTH         = 33;
  localparam int LINE_OFFSET_WIDTH      = 6;

  typedef logic [REQ_ADDR_WIDTH-1:0] req_addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } linefill_state_e;

  // Set index sits directly above the 64-byte line offset; the tag is everything above it.
  function automatic logic [ICACHE_INDEX_WIDTH-1:0] addr_index(input req_addr_t addr);
    return addr[LINE_OFFSET_WIDTH +: ICACHE_INDEX_WIDTH];
  endfunction

  function automatic logic [ICACHE_TAG_WIDTH-1:0] addr_tag(input req_addr_t addr);
    return addr[REQ_ADDR_WIDTH-1 -: ICACHE_TAG_WIDTH];
  endfunction

endpackage

// File: rtl/icache_linefill_ctrl_if.sv
// Refill beat channel, MSHR lookup, data/tag RAM write ports and retire signals.
interface icache_linefill_ctrl_if;
  import toy_pack::*;

  logic                                         rxdat_vld;
  logic                                         rxdat_rdy;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]            rxdat_txnid;
  logic [REFILL_BEAT_CNT_WIDTH-1:0]             rxdat_beat;
  logic                                         rxdat_err;
  logic [REFILL_BEAT_WIDTH-1:0]                 rxdat_data;

  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]            entry_sel;
  req_addr_t                                    entry_addr;
  logic                                         entry_way;

  logic                                         dataram_wr_vld;
  logic                                         dataram_wr_rdy;
  logic                                         dataram_wr_way;
  logic [ICACHE_INDEX_WIDTH-1:0]                dataram_wr_index;
  logic [REFILL_BEAT_WIDTH*REFILL_BEAT_NUM-1:0] dataram_wr_data;

  logic                                         tagram_wr_vld;
  logic                                         tagram_wr_rdy;
  logic                                         tagram_wr_way;
  logic [ICACHE_INDEX_WIDTH-1:0]                tagram_wr_index;
  logic [ICACHE_TAG_WIDTH-1:0]                  tagram_wr_tag;

  logic                                         linefill_done;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]            linefill_ack_index;
  logic                                         linefill_err;
  logic                                         proto_err;

  modport master (
    input  rxdat_vld, rxdat_txnid, rxdat_beat, rxdat_err, rxdat_data,
    output rxdat_rdy,
    output entry_sel,
    input  entry_addr, entry_way,
    output dataram_wr_vld, dataram_wr_way, dataram_wr_index, dataram_wr_data,
    input  dataram_wr_rdy,
    output tagram_wr_vld, tagram_wr_way, tagram_wr_index, tagram_wr_tag,
    input  tagram_wr_rdy,
    output linefill_done, linefill_ack_index, linefill_err, proto_err
  );

  modport slave (
    output rxdat_vld, rxdat_txnid, rxdat_beat, rxdat_err, rxdat_data,
    input  rxdat_rdy,
    input  entry_sel,
    output entry_addr, entry_way,
    input  dataram_wr_vld, dataram_wr_way, dataram_wr_index, dataram_wr_data,
    output dataram_wr_rdy,
    input  tagram_wr_vld, tagram_wr_way, tagram_wr_index, tagram_wr_tag,
    output tagram_wr_rdy,
    input  linefill_done, linefill_ack_index, linefill_err, proto_err
  );

endinterface

// File: rtl/icache_line_assembler.sv
// Refill beat buffer: one slot per beat, exposed as a packed line with beat 0 in the LSBs.
module icache_line_assembler #(
  parameter int BEAT_WIDTH = 128,
  parameter int BEAT_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(BEAT_NUM)-1:0]    wr_slot,
  input  logic [BEAT_WIDTH-1:0]          wr_data,
  output logic [BEAT_WIDTH*BEAT_NUM-1:0] line_data
);

  logic [BEAT_NUM-1:0][BEAT_WIDTH-1:0] slot_q;
  logic [BEAT_NUM-1:0][BEAT_WIDTH-1:0] slot_d;

  // next-state of the beat slots
  always_comb begin
    slot_d = slot_q;
    if (wr_en) begin
      slot_d[wr_slot] = wr_data;
    end else begin
      slot_d = slot_q;
    end
  end

  // slot storage
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign line_data = slot_q;

endmodule

// File: rtl/icache_linefill_ctrl.sv
// Icache refill controller: gathers refill beats into a line, writes data/tag RAMs at the
// owning MSHR's way/index, then pulses a retire back to the MSHR file.
module icache_linefill_ctrl
  import toy_pack::*;
(
  input  logic                   clk,
  input  logic                   rst,
  icache_linefill_ctrl_if.master bus
);

  localparam int BCW    = REFILL_BEAT_CNT_WIDTH;
  localparam int LINE_W = REFILL_BEAT_WIDTH * REFILL_BEAT_NUM;
  localparam int IW     = MSHR_ENTRY_INDEX_WIDTH;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_WRITE   = WRITE;
  localparam logic [1:0] ST_DONE    = DONE;

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(REFILL_BEAT_NUM - 1);

  logic [1:0]                    state_q, state_d;
  logic [BCW-1:0]                beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]                 txnid_q, txnid_d;
  logic                          way_q, way_d;
  logic [ICACHE_INDEX_WIDTH-1:0] index_q, index_d;
  logic [ICACHE_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                          err_acc_q, err_acc_d;
  logic                          data_vld_q, data_vld_d;
  logic                          tag_vld_q, tag_vld_d;
  logic                          done_q, done_d;
  logic                          lf_err_q, lf_err_d;
  logic                          proto_err_q, proto_err_d;

  logic                          accepting_s;
  logic                          beat_fire_s;
  logic                          data_hs_s;
  logic                          tag_hs_s;
  logic                          line_err_s;
  logic                          buf_wr_en_s;
  logic [LINE_W-1:0]             line_data_s;

  assign accepting_s = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign beat_fire_s = bus.rxdat_vld & accepting_s;
  assign data_hs_s   = data_vld_q & bus.dataram_wr_rdy;
  assign tag_hs_s    = tag_vld_q & bus.tagram_wr_rdy;
  assign line_err_s  = err_acc_q | bus.rxdat_err;

  assign bus.rxdat_rdy = accepting_s;
  assign bus.entry_sel = (state_q == ST_IDLE) ? bus.rxdat_txnid : txnid_q;

  // FSM, beat acceptance, protocol checking and RAM handshake tracking
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    txnid_d     = txnid_q;
    way_d       = way_q;
    index_d     = index_q;
    tag_d       = tag_q;
    err_acc_d   = err_acc_q;
    data_vld_d  = data_vld_q;
    tag_vld_d   = tag_vld_q;
    done_d      = done_q;
    lf_err_d    = lf_err_q;
    proto_err_d = proto_err_q;
    buf_wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat_fire_s && (bus.rxdat_beat == '0)) begin
          txnid_d     = bus.rxdat_txnid;
          way_d       = bus.entry_way;
          index_d     = addr_index(bus.entry_addr);
          tag_d       = addr_tag(bus.entry_addr);
          err_acc_d   = bus.rxdat_err;
          buf_wr_en_s = 1'b1;
          beat_cnt_d  = BCW'(1);
          state_d     = ST_COLLECT;
        end else if (beat_fire_s) begin
          proto_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (beat_fire_s && (bus.rxdat_beat == beat_cnt_q) && (bus.rxdat_txnid == txnid_q)) begin
          buf_wr_en_s = 1'b1;
          err_acc_d   = line_err_s;
          if (beat_cnt_q == LAST_BEAT) begin
            // an errored line never reaches the RAMs
            beat_cnt_d = '0;
            state_d    = ST_WRITE;
            data_vld_d = ~line_err_s;
            tag_vld_d  = ~line_err_s;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end else if (beat_fire_s) begin
          proto_err_d = 1'b1;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (data_hs_s) begin
          data_vld_d = 1'b0;
        end else begin
          data_vld_d = data_vld_q;
        end
        if (tag_hs_s) begin
          tag_vld_d = 1'b0;
        end else begin
          tag_vld_d = tag_vld_q;
        end
        if ((!data_vld_q || data_hs_s) && (!tag_vld_q || tag_hs_s)) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          lf_err_d = err_acc_q;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        done_d   = 1'b0;
        lf_err_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      txnid_q     <= '0;
      way_q       <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
      err_acc_q   <= 1'b0;
      data_vld_q  <= 1'b0;
      tag_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      lf_err_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      txnid_q     <= txnid_d;
      way_q       <= way_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      err_acc_q   <= err_acc_d;
      data_vld_q  <= data_vld_d;
      tag_vld_q   <= tag_vld_d;
      done_q      <= done_d;
      lf_err_q    <= lf_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  icache_line_assembler #(
    .BEAT_WIDTH (REFILL_BEAT_WIDTH),
    .BEAT_NUM   (REFILL_BEAT_NUM)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (buf_wr_en_s),
    .wr_slot   (beat_cnt_q),
    .wr_data   (bus.rxdat_data),
    .line_data (line_data_s)
  );

  assign bus.dataram_wr_vld     = data_vld_q;
  assign bus.dataram_wr_way     = way_q;
  assign bus.dataram_wr_index   = index_q;
  assign bus.dataram_wr_data    = line_data_s;
  assign bus.tagram_wr_vld      = tag_vld_q;
  assign bus.tagram_wr_way      = way_q;
  assign bus.tagram_wr_index    = index_q;
  assign bus.tagram_wr_tag      = tag_q;
  assign bus.linefill_done      = done_q;
  assign bus.linefill_ack_index = txnid_q;
  assign bus.linefill_err       = lf_err_q;
  assign bus.proto_err          = proto_err_q;

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Bench for icache_linefill_ctrl: line-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized refills with RAM back-pressure.
module tb_icache_linefill_ctrl;
  import toy_pack::*;

  localparam int BW  = REFILL_BEAT_WIDTH;
  localparam int BN  = REFILL_BEAT_NUM;
  localparam int LW  = BW * BN;
  localparam int TW  = MSHR_ENTRY_INDEX_WIDTH;
  localparam int BCW = REFILL_BEAT_CNT_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_linefill_ctrl_if bus ();
  icache_linefill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // MSHR file stand-in: combinational lookup by entry_sel
  req_addr_t mshr_addr [MSHR_ENTRY_NUM];
  logic      mshr_way  [MSHR_ENTRY_NUM];
  assign bus.entry_addr = mshr_addr[bus.entry_sel];
  assign bus.entry_way  = mshr_way[bus.entry_sel];

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  // line-level model
  bit            m_proto, m_wphase, m_dphase, m_pend_d, m_pend_t, m_acc, m_way, m_err;
  int            m_cnt;
  logic [TW-1:0] m_txn;
  req_addr_t     m_addr;
  logic [BW-1:0] m_buf [BN];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_line();
    logic [LW-1:0] l = '0;
    for (int i = 0; i < BN; i++) l |= LW'(m_buf[i]) << (BW * i);
    return l;
  endfunction

  task automatic model_reset();
    m_proto = 0; m_wphase = 0; m_dphase = 0; m_pend_d = 0; m_pend_t = 0;
    m_cnt = 0; m_txn = '0; m_err = 0; m_way = 0; m_addr = '0;
  endtask

  task automatic check_outputs();
    bit            rdy_e;
    logic [TW-1:0] sel_e;
    logic [6:0]    idx_e;
    logic [19:0]   tag_e;
    rdy_e = !(m_wphase || m_dphase);
    idx_e = 7'(m_addr >> 6);
    tag_e = 20'(m_addr >> 13);
    chk("rxdat_rdy", LW'(bus.rxdat_rdy), LW'(rdy_e));
    if (rdy_e) begin
      sel_e = (m_cnt == 0) ? bus.rxdat_txnid : m_txn;
      chk("entry_sel", LW'(bus.entry_sel), LW'(sel_e));
    end
    chk("dataram_wr_vld", LW'(bus.dataram_wr_vld), LW'(m_pend_d));
    chk("tagram_wr_vld", LW'(bus.tagram_wr_vld), LW'(m_pend_t));
    chk("linefill_done", LW'(bus.linefill_done), LW'(m_dphase));
    chk("proto_err", LW'(bus.proto_err), LW'(m_proto));
    if (m_pend_d) begin
      chk("dataram_wr_way", LW'(bus.dataram_wr_way), LW'(m_way));
      chk("dataram_wr_index", LW'(bus.dataram_wr_index), LW'(idx_e));
      chk("dataram_wr_data", bus.dataram_wr_data, exp_line());
    end
    if (m_pend_t) begin
      chk("tagram_wr_way", LW'(bus.tagram_wr_way), LW'(m_way));
      chk("tagram_wr_index", LW'(bus.tagram_wr_index), LW'(idx_e));
      chk("tagram_wr_tag", LW'(bus.tagram_wr_tag), LW'(tag_e));
    end
    if (m_dphase) begin
      chk("linefill_ack_index", LW'(bus.linefill_ack_index), LW'(m_txn));
      chk("linefill_err", LW'(bus.linefill_err), LW'(m_err));
    end
  endtask

  // what the upcoming clock edge does, given the inputs now applied
  task automatic model_update();
    m_acc = 0;
    if (rst) begin
      model_reset();
    end else if (m_dphase) begin
      m_dphase = 0;
    end else if (m_wphase) begin
      if (m_pend_d && bus.dataram_wr_rdy) m_pend_d = 0;
      if (m_pend_t && bus.tagram_wr_rdy) m_pend_t = 0;
      if (!m_pend_d && !m_pend_t) begin
        m_wphase = 0;
        m_dphase = 1;
      end
    end else if (bus.rxdat_vld) begin
      m_acc = 1;
      if (m_cnt == 0) begin
        if (bus.rxdat_beat != '0) m_proto = 1;
        else begin
          m_txn = bus.rxdat_txnid; m_addr = mshr_addr[bus.rxdat_txnid];
          m_way = mshr_way[bus.rxdat_txnid]; m_err = bus.rxdat_err;
          m_buf[0] = bus.rxdat_data; m_cnt = 1;
        end
      end else if (int'(bus.rxdat_beat) != m_cnt || bus.rxdat_txnid != m_txn) begin
        m_proto = 1;
      end else begin
        m_buf[m_cnt] = bus.rxdat_data;
        m_err = m_err | bus.rxdat_err;
        m_cnt++;
        if (m_cnt == BN) begin
          m_cnt = 0; m_wphase = 1; m_pend_d = !m_err; m_pend_t = !m_err;
        end
      end
    end
  endtask

  task automatic step();
    if (rand_rdy) begin
      bus.dataram_wr_rdy = 1'($urandom_range(0, 1));
      bus.tagram_wr_rdy  = 1'($urandom_range(0, 1));
    end
    #1;
    check_outputs();
    model_update();
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [TW-1:0] t, input int b, input bit e,
                           input logic [BW-1:0] d, output int waited);
    bus.rxdat_vld = 1'b1; bus.rxdat_txnid = t; bus.rxdat_beat = BCW'(b);
    bus.rxdat_err = e; bus.rxdat_data = d;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!m_acc && waited < 40);
    if (!m_acc) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout actual=not_accepted expected=accepted");
    end
    bus.rxdat_vld = 1'b0;
  endtask

  task automatic send_line(input logic [TW-1:0] t, input int err_beat, input logic [7:0] base);
    int w;
    logic [7:0] b;
    for (int i = 0; i < BN; i++) begin
      b = base + 8'(i);
      send_beat(t, i, (i == err_beat), {16{b}}, w);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_wphase || m_dphase) && n < 40) begin
      step();
      n++;
    end
    if (m_wphase || m_dphase) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  initial begin
    int w, dv_cnt, tv_cnt, done_at, vld_seen, err_at_done, ack_at_done, bad_b;
    logic [7:0] b;
    bit inj;
    logic [TW-1:0] t;

    rst = 1'b1;
    bus.rxdat_vld = 0; bus.rxdat_txnid = '0; bus.rxdat_beat = '0;
    bus.rxdat_err = 0; bus.rxdat_data = '0;
    bus.dataram_wr_rdy = 1; bus.tagram_wr_rdy = 1;
    for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
      mshr_addr[i] = '0;
      mshr_way[i]  = 1'b0;
    end
    mshr_addr[5] = 33'h1_2345_6780; mshr_way[5] = 1'b1;
    mshr_addr[1] = 33'h0_0000_1FC0; mshr_way[1] = 1'b0;
    mshr_addr[6] = 33'h1_FFFF_FFC0; mshr_way[6] = 1'b1;
    mshr_addr[2] = 33'h0_ABCD_E040; mshr_way[2] = 1'b0;
    mshr_addr[4] = 33'h0_1357_9BC0; mshr_way[4] = 1'b1;
    mshr_addr[7] = 33'h1_0246_8AC0; mshr_way[7] = 1'b0;
    model_reset();
    @(negedge clk);
    step(); step();
    chk("reset_rdy", LW'(bus.rxdat_rdy), LW'(1'b1));
    chk("reset_vlds", LW'({bus.dataram_wr_vld, bus.tagram_wr_vld}), LW'(2'b00));
    chk("reset_done_err", LW'({bus.linefill_done, bus.linefill_err, bus.proto_err}), LW'(3'b000));
    chk("reset_data", bus.dataram_wr_data, LW'(0));
    chk("reset_idx_tag_way", LW'({bus.dataram_wr_index, bus.tagram_wr_tag, bus.tagram_wr_way}), LW'(0));
    rst = 1'b0;
    step();

    // clean refill
    send_line(3'd5, -1, 8'hA0);
    chk("clean_T1_vlds", LW'({bus.dataram_wr_vld, bus.tagram_wr_vld}), LW'(2'b11));
    chk("clean_index", LW'(bus.dataram_wr_index), LW'(7'h1E));
    chk("clean_tag", LW'(bus.tagram_wr_tag), LW'(20'h91A2B));
    chk("clean_way", LW'(bus.dataram_wr_way), LW'(1'b1));
    chk("clean_data_beat0", LW'(bus.dataram_wr_data[127:0]), LW'({16{8'hA0}}));
    chk("clean_data_beat3", LW'(bus.dataram_wr_data[511:384]), LW'({16{8'hA3}}));
    step();
    chk("clean_T2_done", LW'({bus.linefill_done, bus.linefill_ack_index, bus.linefill_err}),
        LW'({1'b1, 3'd5, 1'b0}));
    step();
    chk("clean_T3_done_low", LW'(bus.linefill_done), LW'(1'b0));

    // data RAM back-pressure for three cycles
    bus.dataram_wr_rdy = 0;
    send_line(3'd1, -1, 8'h10);
    dv_cnt = 0; tv_cnt = 0; done_at = 0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.dataram_wr_vld) dv_cnt++;
      if (bus.tagram_wr_vld) tv_cnt++;
      if (bus.linefill_done) done_at = k;
      bus.dataram_wr_rdy = (k >= 4);
      step();
    end
    chk("bp_data_vld_cycles", LW'(dv_cnt), LW'(4));
    chk("bp_tag_vld_cycles", LW'(tv_cnt), LW'(1));
    chk("bp_done_cycle", LW'(done_at), LW'(5));

    // error on beat 2, RAMs not ready
    bus.dataram_wr_rdy = 0; bus.tagram_wr_rdy = 0;
    send_line(3'd6, 2, 8'h60);
    vld_seen = 0; done_at = 0; err_at_done = 0;
    for (int k = 1; k <= 3; k++) begin
      if (bus.dataram_wr_vld || bus.tagram_wr_vld) vld_seen = 1;
      if (bus.linefill_done) begin
        done_at = k;
        err_at_done = int'(bus.linefill_err);
      end
      step();
    end
    chk("err_no_vld", LW'(vld_seen), LW'(0));
    chk("err_done_cycle", LW'(done_at), LW'(2));
    chk("err_flag", LW'(err_at_done), LW'(1));
    bus.dataram_wr_rdy = 1; bus.tagram_wr_rdy = 1;

    // txnid mismatch mid-line
    send_beat(3'd2, 0, 0, {16{8'h20}}, w);
    send_beat(3'd3, 1, 0, {16{8'hEE}}, w);
    chk("proto_set", LW'(bus.proto_err), LW'(1'b1));
    for (int i = 1; i < BN; i++) begin
      b = 8'h20 + 8'(i);
      send_beat(3'd2, i, 0, {16{b}}, w);
    end
    chk("proto_line_beat1", LW'(bus.dataram_wr_data[255:128]), LW'({16{8'h21}}));
    ack_at_done = -1;
    for (int k = 0; k < 4; k++) begin
      if (bus.linefill_done) ack_at_done = int'(bus.linefill_ack_index);
      step();
    end
    chk("proto_line_ack", LW'(ack_at_done), LW'(2));

    // next line presented during WRITE, then reset mid-COLLECT
    send_line(3'd4, -1, 8'h40);
    send_beat(3'd7, 0, 0, {16{8'h70}}, w);
    chk("bp_beat0_wait", LW'(w), LW'(3));
    send_beat(3'd7, 1, 0, {16{8'h71}}, w);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_proto_clear", LW'(bus.proto_err), LW'(1'b0));
    chk("rst_rdy", LW'(bus.rxdat_rdy), LW'(1'b1));
    for (int k = 0; k < 5; k++) step();

    // randomized refills with random RAM readiness, errors and protocol violations
    for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
      mshr_addr[i] = {1'($urandom), $urandom};
      mshr_way[i]  = 1'($urandom);
    end
    rand_rdy = 1'b1;
    for (int ln = 0; ln < 60; ln++) begin
      t = TW'($urandom_range(0, MSHR_ENTRY_NUM - 1));
      for (int bt = 0; bt < BN; bt++) begin
        inj = ($urandom_range(0, 9) == 0);
        if (inj) begin
          if (bt == 0) begin
            send_beat(t, $urandom_range(1, BN - 1), 0, {4{$urandom}}, w);
          end else if ($urandom_range(0, 1) == 0) begin
            bad_b = (bt + 1) % BN;
            send_beat(t, bad_b, 0, {4{$urandom}}, w);
          end else begin
            send_beat(t ^ TW'(1), bt, 0, {4{$urandom}}, w);
          end
        end
        send_beat(t, bt, ($urandom_range(0, 7) == 0), {$urandom, $urandom, $urandom, $urandom}, w);
        for (int g = $urandom_range(0, 2); g > 0; g--) step();
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
